// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and the default frame length (start + 8 data + stop).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int DEFAULT_FRAME_BITS = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after
// i_rr_ptr, searching upward and wrapping to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_winner,
    output logic                       o_any_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               w_idx;
    logic [IDX_W-1:0] w_sel;

    // Walk the search order backwards so the last hit written is the
    // highest-priority one (closest to the pointer).
    always_comb begin
        o_winner    = '0;
        o_any_valid = 1'b0;
        w_idx       = 0;
        w_sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = IDX_W'(w_idx);
            if (i_req[w_sel]) begin
                o_winner    = w_sel;
                o_any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte sources: round-robin grant,
// one load strobe, a fixed-length send window, then an idle-line gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int FRAME_BITS   = DEFAULT_FRAME_BITS,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_enable,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDX_W     = $clog2(NUM_REQ);
    localparam int FRAME_LEN = FRAME_BITS * CLKS_PER_BIT;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_ready;
    logic               r_enable;
    logic               r_start;
    logic [7:0]         r_data;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rrPtr;
    logic [CNT_W-1:0]   r_frameCnt;
    logic [GAP_W-1:0]   r_gapCnt;

    logic [IDX_W-1:0]   w_winner;
    logic               w_anyValid;
    logic [7:0]         w_winByte;
    logic [IDX_W-1:0]   w_nextPtr;
    logic [NUM_REQ-1:0] w_winOneHot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rrPtr),
        .o_winner    (w_winner),
        .o_any_valid (w_anyValid)
    );

    assign w_winByte   = req_data[{w_winner, 3'b000} +: 8];
    assign w_nextPtr   = (w_winner == IDX_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    assign w_winOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;

    // Requests are only sampled in IDLE, so anything requesters do while a
    // frame is in flight has no effect on tx_data or the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ready    <= '0;
            r_enable   <= 1'b0;
            r_start    <= 1'b0;
            r_data     <= 8'h00;
            r_grant    <= '0;
            r_rrPtr    <= '0;
            r_frameCnt <= '0;
            r_gapCnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_state  <= LOAD;
                        r_data   <= w_winByte;
                        r_grant  <= w_winner;
                        r_rrPtr  <= w_nextPtr;
                        r_ready  <= w_winOneHot;
                        r_enable <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state    <= SEND;
                    r_ready    <= '0;
                    r_enable   <= 1'b0;
                    r_start    <= 1'b1;
                    r_frameCnt <= CNT_W'(FRAME_LEN);
                end
                SEND: begin
                    if (r_frameCnt == CNT_W'(1)) begin
                        r_state    <= GAP;
                        r_start    <= 1'b0;
                        r_frameCnt <= '0;
                        r_gapCnt   <= GAP_W'(GAP_CYCLES);
                    end else begin
                        r_frameCnt <= r_frameCnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_gapCnt == GAP_W'(1)) begin
                        r_state  <= IDLE;
                        r_gapCnt <= '0;
                    end else begin
                        r_gapCnt <= r_gapCnt - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_ready;
    assign tx_enable = r_enable;
    assign tx_start  = r_start;
    assign tx_data   = r_data;
    assign grant_id  = r_grant;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler at default parameters
// (4 requesters, 10-cycle send window, 1-cycle gap, 13-cycle frame period).
module tb_uart_tx_scheduler;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_enable;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    int   compareCount  = 0;
    int   mismatchCount = 0;
    int   cycleCount    = 0;
    int   startRun      = 0;
    logic prevStart     = 1'b0;

    uart_tx_scheduler #(
        .NUM_REQ      (4),
        .CLKS_PER_BIT (1),
        .FRAME_BITS   (10),
        .GAP_CYCLES   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_enable (tx_enable),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic awaitGrant(output int grantCycle);
        grantCycle = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (req_ready != 4'b0000) begin
                grantCycle = cycleCount;
                break;
            end
        end
        if (grantCycle < 0) checkOutput("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic awaitIdle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'd1, 32'd0);
    endtask

    // Protocol invariants sampled on the falling edge of every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            startRun  = 0;
            prevStart = 1'b0;
        end else begin
            checkOutput("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            checkOutput("ready_only_in_load", 32'((req_ready == 4'b0000) || tx_enable), 32'd1);
            checkOutput("enable_start_excl", 32'(tx_enable && tx_start), 32'd0);
            if (tx_start) begin
                startRun++;
            end else if (prevStart) begin
                checkOutput("start_length", startRun, 32'd10);
                startRun = 0;
            end
            prevStart = tx_start;
        end
    end

    initial begin
        int   t0;
        int   t1;
        int   startCount;
        int   n;
        logic stable;
        logic [7:0] allBytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] fairIds  [4] = '{2'd2, 2'd3, 2'd2, 2'd3};
        logic [7:0] fairBytes[4] = '{8'h77, 8'h88, 8'h77, 8'h88};

        t0 = 0;
        applyStimulus(4'b0000, 32'h0);
        repeat (3) tick();
        checkOutput("rst_busy", busy, 32'd0);
        checkOutput("rst_enable", tx_enable, 32'd0);
        checkOutput("rst_start", tx_start, 32'd0);
        checkOutput("rst_data", tx_data, 32'h00);
        checkOutput("rst_grant", grant_id, 32'd0);
        checkOutput("rst_ready", req_ready, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle_no_req_busy", busy, 32'd0);

        // Single request: one LOAD, ten SEND cycles, one GAP, then idle.
        applyStimulus(4'b0001, 32'h0000_00C9);
        awaitGrant(t0);
        checkOutput("t1_ready", req_ready, 32'h1);
        checkOutput("t1_enable", tx_enable, 32'd1);
        checkOutput("t1_start_in_load", tx_start, 32'd0);
        checkOutput("t1_data", tx_data, 32'hC9);
        checkOutput("t1_grant", grant_id, 32'd0);
        checkOutput("t1_busy", busy, 32'd1);
        applyStimulus(4'b0000, 32'h0000_00C9);
        startCount = 0;
        repeat (11) begin
            tick();
            startCount += int'(tx_start);
        end
        checkOutput("t1_start_cycles", startCount, 32'd10);
        checkOutput("t1_gap_busy", busy, 32'd1);
        checkOutput("t1_gap_start", tx_start, 32'd0);
        tick();
        checkOutput("t1_idle_busy", busy, 32'd0);
        checkOutput("t1_idle_enable", tx_enable, 32'd0);
        checkOutput("t1_idle_data_held", tx_data, 32'hC9);

        // All four requesting after reset: 0,1,2,3 at 13-cycle spacing.
        applyReset();
        applyStimulus(4'b1111, 32'h4433_2211);
        for (int i = 0; i < 4; i++) begin
            awaitGrant(t1);
            checkOutput($sformatf("t2_ready_%0d", i), req_ready, 32'd1 << i);
            checkOutput($sformatf("t2_grant_%0d", i), grant_id, i);
            checkOutput($sformatf("t2_data_%0d", i), tx_data, allBytes[i]);
            if (i > 0) checkOutput($sformatf("t2_period_%0d", i), t1 - t0, 32'd13);
            t0 = t1;
            req_valid[i] = 1'b0;
        end
        awaitIdle();

        // Two requesters holding continuously must alternate.
        applyStimulus(4'b1100, 32'h8877_6655);
        for (int i = 0; i < 4; i++) begin
            awaitGrant(t1);
            checkOutput($sformatf("t3_grant_%0d", i), grant_id, fairIds[i]);
            checkOutput($sformatf("t3_ready_%0d", i), req_ready, 32'd1 << fairIds[i]);
            checkOutput($sformatf("t3_data_%0d", i), tx_data, fairBytes[i]);
        end
        applyStimulus(4'b0000, 32'h8877_6655);
        awaitIdle();

        // Source byte changes mid-frame; the latched byte must not move.
        applyStimulus(4'b0001, 32'h0000_00A5);
        awaitGrant(t1);
        checkOutput("t4_load_data", tx_data, 32'hA5);
        applyStimulus(4'b0000, 32'h0000_00A5);
        repeat (3) tick();
        applyStimulus(4'b0000, 32'h0000_005A);
        stable = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            if (tx_data !== 8'hA5) stable = 1'b0;
            tick();
            n++;
        end
        checkOutput("t4_data_stable", stable, 32'd1);
        checkOutput("t4_idle", busy, 32'd0);
        checkOutput("t4_idle_data", tx_data, 32'hA5);

        // Pointer is 1 here, so requester 2 wins and moves it to 3; the reset
        // must pull it back to 0 so that 4'b1010 then favours requester 1.
        applyStimulus(4'b0100, 32'h003C_0000);
        awaitGrant(t1);
        checkOutput("t5_pre_grant", grant_id, 32'd2);
        checkOutput("t5_pre_data", tx_data, 32'h3C);
        applyStimulus(4'b0000, 32'h0);
        repeat (4) tick();
        checkOutput("t5_in_send", tx_start, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_abort_start", tx_start, 32'd0);
        checkOutput("t5_abort_busy", busy, 32'd0);
        checkOutput("t5_abort_data", tx_data, 32'h00);
        checkOutput("t5_abort_grant", grant_id, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(4'b1010, 32'h4D00_2B00);
        awaitGrant(t1);
        checkOutput("t5_post_grant", grant_id, 32'd1);
        checkOutput("t5_post_ready", req_ready, 32'h2);
        checkOutput("t5_post_data", tx_data, 32'h2B);
        applyStimulus(4'b0000, 32'h0);
        awaitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
